// File: rtl/he_coeff_scaler.sv
// Multi-lane (coeff*t/q) mod q scaler with floor or round-to-nearest division.
// Lanes share one FSM and counter, one quotient/remainder bit per cycle.
module he_coeff_scaler #(
    parameter int WIDTH = 32,
    parameter int LANES = 4,
    parameter int CNT_W = $clog2(2*WIDTH+1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       t_i,
    input  logic [WIDTH-1:0]       q_i,
    input  logic                   mode_i,
    input  logic [LANES*WIDTH-1:0] data_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [LANES*WIDTH-1:0] data_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   err_o
);
    localparam int PW = 2*WIDTH;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PW-1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_MOD,
        S_OUT
    } state_t;

    state_t state_q, state_d;

    logic [LANES-1:0][PW-1:0]    acc_q;
    logic [LANES-1:0][PW-1:0]    acc_nxt;
    logic [LANES-1:0][PW-1:0]    acc_ld;
    logic [LANES-1:0][WIDTH-1:0] rem_q;
    logic [LANES-1:0][WIDTH-1:0] rem_nxt;
    logic [LANES-1:0][WIDTH-1:0] shl;
    logic [LANES-1:0]            ge;
    logic [WIDTH-1:0]            mod_q;
    logic                        zero_q;
    logic [CNT_W-1:0]            cnt_q;
    logic                        last;

    assign last    = (cnt_q == LAST);
    assign ready_o = (state_q == S_IDLE);
    assign valid_o = (state_q == S_OUT);

    // A set remainder MSB means the shifted value is at least 2^WIDTH > q.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            shl[k]     = {rem_q[k][WIDTH-2:0], acc_q[k][PW-1]};
            ge[k]      = rem_q[k][WIDTH-1] | (shl[k] >= mod_q);
            rem_nxt[k] = ge[k] ? shl[k] - mod_q : shl[k];
            acc_nxt[k] = {acc_q[k][PW-2:0], ge[k]};
            acc_ld[k]  = PW'(data_i[k*WIDTH +: WIDTH]) * PW'(t_i)
                       + (mode_i ? PW'(q_i[WIDTH-1:1]) : '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (valid_i) state_d = S_DIV;
            S_DIV:  if (last)    state_d = S_MOD;
            S_MOD:  if (last)    state_d = S_OUT;
            S_OUT:  if (ready_i) state_d = S_IDLE;
            default:             state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q  <= '0;
            rem_q  <= '0;
            mod_q  <= '0;
            zero_q <= 1'b0;
            cnt_q  <= '0;
            data_o <= '0;
            err_o  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (valid_i) begin
                        acc_q  <= acc_ld;
                        rem_q  <= '0;
                        mod_q  <= q_i;
                        zero_q <= (q_i == '0);
                        cnt_q  <= '0;
                    end
                end
                S_DIV: begin
                    acc_q <= acc_nxt;
                    cnt_q <= last ? '0 : cnt_q + 1'b1;
                    // Quotient stays in acc; MOD restarts from a clean remainder.
                    rem_q <= last ? '0 : rem_nxt;
                end
                S_MOD: begin
                    acc_q <= acc_nxt;
                    rem_q <= rem_nxt;
                    cnt_q <= last ? '0 : cnt_q + 1'b1;
                    if (last) begin
                        err_o <= zero_q;
                        for (int k = 0; k < LANES; k++) begin
                            data_o[k*WIDTH +: WIDTH] <= zero_q ? '1 : rem_nxt[k];
                        end
                    end
                end
                S_OUT: begin
                    if (ready_i) err_o <= 1'b0;
                end
                default: begin
                    cnt_q <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_he_coeff_scaler.sv
// Scoreboard bench for he_coeff_scaler: directed beats, latency,
// backpressure, divide-by-zero and mid-operation reset.
module tb_he_coeff_scaler;
    localparam int W = 32;
    localparam int L = 4;
    localparam int LAT = 4*W;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   t_i, q_i;
    logic           mode_i;
    logic [L*W-1:0] data_i;
    logic           valid_i;
    logic           ready_o;
    logic [L*W-1:0] data_o;
    logic           valid_o;
    logic           ready_i;
    logic           err_o;

    typedef struct {
        logic [L*W-1:0] data;
        logic           err;
        int             acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic seen = 1'b0;

    he_coeff_scaler #(.WIDTH(W), .LANES(L)) dut (
        .clk(clk), .rst(rst), .t_i(t_i), .q_i(q_i), .mode_i(mode_i),
        .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
        .err_o(err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [L*W-1:0] pk(input logic [W-1:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic chk(input string name, input logic [L*W-1:0] act, exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // Monitor: compares each result beat when valid_o first appears.
    always @(negedge clk) begin
        if (!rst) begin
            seen = 1'b0;
        end else if (valid_o && !seen) begin
            exp_t e;
            seen = 1'b1;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %h expected none", data_o);
            end else begin
                e = sb.pop_front();
                chk("data", data_o, e.data);
                chk("err", {127'd0, err_o}, {127'd0, e.err});
                chk("latency", (L*W)'(cyc - e.acc), (L*W)'(LAT));
            end
        end else if (!valid_o) begin
            seen = 1'b0;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic send(input logic [L*W-1:0] d, input logic [W-1:0] t,
                        input logic [W-1:0] q, input logic m,
                        input logic [L*W-1:0] ed, input logic ee);
        exp_t e;
        int n = 0;
        while (!ready_o && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got 0 expected 1");
        end
        valid_i = 1'b1;
        data_i  = d;
        t_i     = t;
        q_i     = q;
        mode_i  = m;
        e.data  = ed;
        e.err   = ee;
        e.acc   = cyc + 1;
        sb.push_back(e);
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || !ready_o) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    task automatic chk_reset_outs(input string name);
        chk({name, "_ready"}, {127'd0, ready_o}, {127'd0, 1'b1});
        chk({name, "_valid"}, {127'd0, valid_o}, '0);
        chk({name, "_err"}, {127'd0, err_o}, '0);
        chk({name, "_data"}, data_o, '0);
    endtask

    initial begin
        logic [L*W-1:0] bp;
        int n;
        rst = 1'b0;
        t_i = '0;
        q_i = '0;
        mode_i = 1'b0;
        data_i = '0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outs("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        send(pk(100, 7, 1, 10), 21, 7, 1'b0, pk(6, 0, 3, 2), 1'b0);
        send(pk(11, 0, 0, 0), 3, 7, 1'b0, pk(4, 0, 0, 0), 1'b0);
        send(pk(11, 0, 0, 0), 3, 7, 1'b1, pk(5, 0, 0, 0), 1'b0);
        send({L{32'hFFFF_FFFF}}, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, '0, 1'b0);
        send({L{32'hFFFF_FFFF}}, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, '0, 1'b0);
        send(pk(5, 9, 123, 77), 13, 0, 1'b0, {L{32'hFFFF_FFFF}}, 1'b1);
        send(pk(100, 0, 0, 0), 21, 7, 1'b0, pk(6, 0, 0, 0), 1'b0);
        wait_idle();

        bp = pk(6, 0, 3, 2);
        ready_i = 1'b0;
        send(pk(100, 7, 1, 10), 21, 7, 1'b0, bp, 1'b0);
        n = 0;
        while (!valid_o && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_reach_out", {127'd0, valid_o}, {127'd0, 1'b1});
        for (int i = 0; i < 10; i++) begin
            valid_i = i[0];
            data_i = {L{32'(i * 32'h1111_1111)}};
            @(posedge clk); #1;
            chk("bp_data", data_o, bp);
            chk("bp_ready", {127'd0, ready_o}, '0);
        end
        ready_i = 1'b1;
        valid_i = 1'b0;
        @(posedge clk); #1;
        chk("rel_ready", {127'd0, ready_o}, {127'd0, 1'b1});
        chk("rel_valid", {127'd0, valid_o}, '0);
        chk("rel_data_hold", data_o, bp);
        repeat (LAT + 10) @(posedge clk);
        #1;

        send(pk(100, 0, 0, 0), 21, 7, 1'b0, pk(6, 0, 0, 0), 1'b0);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        #1;
        chk_reset_outs("midrst");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        send(pk(100, 0, 0, 0), 21, 7, 1'b0, pk(6, 0, 0, 0), 1'b0);
        wait_idle();
        repeat (5) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
